// File: rtl/fabric_pkg.sv
// Shared sizes, signal-pool layout and configuration-frame field offsets.
package fabric_pkg;
  localparam int SIDE_W        = 64;
  localparam int FRAME_W       = 320;
  localparam int NUM_CELLS     = 164;
  localparam int NUM_OUT_FRM   = 8;
  localparam int NUM_FRAMES    = NUM_CELLS + NUM_OUT_FRM;
  localparam int LUT_K         = 6;
  localparam int SEL_W         = 9;
  localparam int POOL_N        = 1 << SEL_W;
  localparam int NUM_OUTS      = 4 * SIDE_W;

  localparam int TOP_BASE      = 0;
  localparam int BOT_BASE      = 64;
  localparam int LEFT_BASE     = 128;
  localparam int RIGHT_BASE    = 192;
  localparam int CELL_BASE     = 256;
  localparam int ZERO_BASE     = 420;

  localparam int TRUTH_LSB     = 0;
  localparam int SEL_LSB       = 64;
  localparam int USE_FF_BIT    = 118;
  localparam int INIT_BIT      = 119;
  localparam int CELL_CFG_W    = INIT_BIT + 1;

  localparam int OUT_FIELD_W   = 10;
  localparam int OUT_PER_FRAME = FRAME_W / OUT_FIELD_W;
endpackage

// File: rtl/fabric_cell.sv
// One 6-LUT logic cell: six pool muxes, truth-table lookup, optional flip-flop.
module fabric_cell
  import fabric_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  ff_en,
  input  logic [CELL_CFG_W-1:0] cfg,
  input  logic [POOL_N-1:0]     pool,
  output logic                  out
);
  logic [LUT_K-1:0] idx;
  logic [63:0]      truth;
  logic             lut;
  logic             q;

  assign truth = cfg[TRUTH_LSB +: 64];

  // Each LUT input picks any pool entry; in0 is the index LSB.
  for (genvar k = 0; k < LUT_K; k++) begin : g_in
    assign idx[k] = pool[cfg[SEL_LSB + SEL_W*k +: SEL_W]];
  end

  assign lut = truth[idx];
  assign out = cfg[USE_FF_BIT] ? q : lut;

  // Reset loads the configured init value and wins over ff_en.
  always_ff @(posedge clock) begin
    if (!rst)       q <= cfg[INIT_BIT];
    else if (ff_en) q <= lut;
  end
endmodule

// File: rtl/fpga_fabric.sv
// LUT fabric top: config frames, signal pool, cell array and output pad muxes.
module fpga_fabric
  import fabric_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic [SIDE_W-1:0]     top_in,
  input  logic [SIDE_W-1:0]     bot_in,
  input  logic [SIDE_W-1:0]     left_in,
  input  logic [SIDE_W-1:0]     right_in,
  output logic [SIDE_W-1:0]     top_out,
  output logic [SIDE_W-1:0]     bot_out,
  output logic [SIDE_W-1:0]     left_out,
  output logic [SIDE_W-1:0]     right_out,
  input  logic                  ff_en,
  input  logic [NUM_FRAMES-1:0] configs_en,
  input  logic [FRAME_W-1:0]    configs_in
);
  logic [FRAME_W-1:0]  cfg [NUM_FRAMES];
  logic [NUM_CELLS-1:0] cell_out;
  logic [POOL_N-1:0]   pool;
  logic [NUM_OUTS-1:0] out_vec;

  // Frame writes; config memory is deliberately untouched by rst.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FRAMES; i++)
      if (configs_en[i]) cfg[i] <= configs_in;
  end

  // Pool order: top, bot, left, right pads, then cells, then constant zeros.
  assign pool = {{(POOL_N-ZERO_BASE){1'b0}}, cell_out,
                 right_in, left_in, bot_in, top_in};

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    fabric_cell u_cell (
      .clock (clock),
      .rst   (rst),
      .ff_en (ff_en),
      .cfg   (cfg[c][CELL_CFG_W-1:0]),
      .pool  (pool),
      .out   (cell_out[c])
    );
  end

  // Output o is field o%32 of output frame o/32; disabled fields drive 0.
  for (genvar o = 0; o < NUM_OUTS; o++) begin : g_out
    logic [OUT_FIELD_W-1:0] fld;
    assign fld        = cfg[NUM_CELLS + o/OUT_PER_FRAME][(o%OUT_PER_FRAME)*OUT_FIELD_W +: OUT_FIELD_W];
    assign out_vec[o] = fld[OUT_FIELD_W-1] & pool[fld[SEL_W-1:0]];
  end

  assign top_out   = out_vec[TOP_BASE   +: SIDE_W];
  assign bot_out   = out_vec[BOT_BASE   +: SIDE_W];
  assign left_out  = out_vec[LEFT_BASE  +: SIDE_W];
  assign right_out = out_vec[RIGHT_BASE +: SIDE_W];
endmodule

// File: tb/tb_fpga_fabric.sv
// Directed bench: zero config, pad pass-through, AND2 cell, toggle FF, reset priority, live reconfig.
module tb_fpga_fabric;
  logic         clock = 1'b0;
  logic         rst;
  logic [63:0]  top_in, bot_in, left_in, right_in;
  logic [63:0]  top_out, bot_out, left_out, right_out;
  logic         ff_en;
  logic [171:0] configs_en;
  logic [319:0] configs_in;

  int checks = 0;
  int failures = 0;

  fpga_fabric dut (
    .clock(clock), .rst(rst),
    .top_in(top_in), .bot_in(bot_in), .left_in(left_in), .right_in(right_in),
    .top_out(top_out), .bot_out(bot_out), .left_out(left_out), .right_out(right_out),
    .ff_en(ff_en), .configs_en(configs_en), .configs_in(configs_in)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] outs();
    return {right_out, left_out, bot_out, top_out};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_frame(input int idx, input logic [319:0] data);
    configs_en = '0;
    configs_en[idx] = 1'b1;
    configs_in = data;
    tick();
    configs_en = '0;
  endtask

  function automatic logic [319:0] make_cell(input logic [63:0] truth,
      input logic [8:0] s0, input logic [8:0] s1, input logic [8:0] s2,
      input logic [8:0] s3, input logic [8:0] s4, input logic [8:0] s5,
      input logic use_ff, input logic init);
    logic [319:0] f;
    f = '0;
    f[63:0]   = truth;
    f[64+:9]  = s0;
    f[73+:9]  = s1;
    f[82+:9]  = s2;
    f[91+:9]  = s3;
    f[100+:9] = s4;
    f[109+:9] = s5;
    f[118]    = use_ff;
    f[119]    = init;
    return f;
  endfunction

  logic [319:0] fr;
  logic [255:0] e;
  logic         qm;

  initial begin
    rst = 1'b0; ff_en = 1'b0; configs_en = '0; configs_in = '0;
    top_in = '0; bot_in = '0; left_in = '0; right_in = '0;
    #2;
    // Zero every frame with a walking one-hot enable.
    for (int i = 0; i < 172; i++) write_frame(i, '0);
    tick();
    rst = 1'b1;
    tick();

    chk("zero_reset", outs(), '0);
    top_in = 64'hDEAD_BEEF_0123_4567; bot_in = '1; left_in = 64'h5555_AAAA_5555_AAAA; right_in = '1;
    ff_en = 1'b1; tick();
    chk("zero_pat1", outs(), '0);
    top_in = '1; bot_in = '0; left_in = '1; right_in = 64'h0F0F;
    tick();
    chk("zero_pat2", outs(), '0);
    ff_en = 1'b0;
    top_in = '0; bot_in = '0; left_in = '0; right_in = '0;

    // Pass-through: right_out[0] = right_in[4].
    fr = '0; fr[9:0] = {1'b1, 9'd196};
    write_frame(170, fr);
    right_in = 64'h10; #1;
    e = '0; e[192] = 1'b1;
    chk("pass_hi", outs(), e);
    right_in = ~64'h10; #1;
    chk("pass_lo", outs(), '0);
    right_in = '1; #1;
    chk("pass_all", outs(), e);
    right_in = '0;

    // AND2 cell 0 routed to top_out[5].
    write_frame(0, make_cell(64'h8, 9'd0, 9'd1, 9'd420, 9'd420, 9'd420, 9'd420, 1'b0, 1'b0));
    fr = '0; fr[59:50] = {1'b1, 9'd256};
    write_frame(164, fr);
    for (int v = 0; v < 4; v++) begin
      top_in = 64'(v); #1;
      e = '0; e[5] = (v == 3);
      chk($sformatf("and2_%0d", v), outs(), e);
    end
    top_in = '0;

    // Toggle cell 1 routed to left_out[3] (output 131: frame 168 field 3).
    write_frame(1, make_cell(64'h1, 9'd257, 9'd420, 9'd420, 9'd420, 9'd420, 9'd420, 1'b1, 1'b0));
    fr = '0; fr[39:30] = {1'b1, 9'd257};
    write_frame(168, fr);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("tog_reset", outs(), '0);
    ff_en = 1'b1;
    qm = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(); qm = ~qm;
      e = '0; e[131] = qm;
      chk($sformatf("tog_%0d", t), outs(), e);
    end
    ff_en = 1'b0;
    tick(); chk("hold_0", outs(), '0);
    tick(); chk("hold_1", outs(), '0);

    // Live reconfig: disable then re-enable the output while toggling.
    ff_en = 1'b1;
    tick(); qm = ~qm;
    e = '0; e[131] = qm; chk("live_run", outs(), e);
    write_frame(168, '0); qm = ~qm;
    chk("live_off0", outs(), '0);
    tick(); qm = ~qm;
    chk("live_off1", outs(), '0);
    write_frame(168, fr); qm = ~qm;
    e = '0; e[131] = qm; chk("live_on0", outs(), e);
    for (int t = 0; t < 2; t++) begin
      tick(); qm = ~qm;
      e = '0; e[131] = qm;
      chk($sformatf("live_on%0d", t + 1), outs(), e);
    end

    // Reset priority: init=1 loads under rst=0 even with ff_en=1.
    write_frame(1, make_cell(64'h1, 9'd257, 9'd420, 9'd420, 9'd420, 9'd420, 9'd420, 1'b1, 1'b1));
    rst = 1'b0;
    e = '0; e[131] = 1'b1;
    tick(); chk("rstpri_0", outs(), e);
    tick(); chk("rstpri_1", outs(), e);
    rst = 1'b1;
    tick(); chk("rstpri_rel", outs(), '0);
    ff_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
